ultrasonic_scan_ctrl: RTL and testbench
=======================================

// Module: ultrasonic_scan_ctrl
// PURPOSE
// - Round-robin scheduler for N_SENS HC-SR04-style ultrasonic rangers sharing one echo-timing datapath.
// - Per sensor: fires trigger pulse, times echo high width, converts to mm, publishes result, enforces crosstalk gap.
// - Sits between the sensor pins and the obstacle-avoidance/motion logic; replaces per-sensor free-running trigger+counter pairs.
// PARAMETERS
// - N_SENS    3        number of sensors scanned (1..4); index 0 scanned first
// - TRIG_CYC  500      trigger high width in clk cycles (10 us @ 50 MHz)
// - WAIT_TO   1500000  max cycles from trigger fall to echo rise before timeout (30 ms)
// - ECHO_MAX  1250000  max echo-high cycles before timeout (25 ms, ~4.25 m)
// - GAP_CYC   3000000  idle cycles after each measurement before next trigger (60 ms)
// - MM_MUL    223      distance_mm = (echo_cycles * MM_MUL) >> 16 (0.0034 mm/cycle @ 50 MHz)
// PORTS
// - clk        in   1          system clock
// - reset      in   1          asynchronous, active-low reset
// - en         in   1          1 = scanning enabled
// - echo       in   N_SENS     raw echo pins, asynchronous
// - trig       out  N_SENS     trigger pins, one-hot or zero
// - dist_bus   out  16*N_SENS  latest distance per sensor, mm; slice i = [16*i+15:16*i]
// - dist_vld   out  1          1-cycle pulse when a slice is updated
// - dist_id    out  2          sensor index of the update flagged by dist_vld
// - timeout    out  N_SENS     sticky per sensor: last measurement timed out
// - busy       out  1          1 whenever state != IDLE
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, sel=0, trig=0, dist_bus=all 16'hFFFF, dist_vld=0, dist_id=0, timeout=0, busy=0, counters=0.
// - echo sampled through 2-FF synchronizer per bit; only echo_s[sel] is used; all timing counts synchronized signal.
// - States:
//   IDLE: en=1 -> TRIG (cnt=0). en=0 -> stay.
//   TRIG: trig[sel]=1 for exactly TRIG_CYC cycles, then -> WAIT (cnt=0).
//   WAIT: echo_s[sel]=1 -> MEAS (cnt=1); cnt reaches WAIT_TO -> RESULT with to_flag=1.
//   MEAS: cnt++ while echo_s[sel]=1; echo_s[sel]=0 -> RESULT (cycles=cnt, to_flag=0); cnt reaches ECHO_MAX -> RESULT with to_flag=1.
//   RESULT (1 cycle): slice[sel] = to_flag ? 16'hFFFF : min((cycles*MM_MUL)>>16, 16'hFFFE); timeout[sel]=to_flag; dist_vld=1, dist_id=sel; -> GAP (cnt=0).
//   GAP: wait GAP_CYC cycles; then sel = (sel==N_SENS-1) ? 0 : sel+1; en=1 -> TRIG, en=0 -> IDLE.
// - Multiply: 21-bit cycles x 16-bit MM_MUL into 37-bit product, then shift; no intermediate truncation.
// - echo already high on entry to WAIT (stuck/late from prior ping): not a rising edge; WAIT requires echo_s low then high, else times out.
// - en dropped mid-measurement: current sensor completes through RESULT and GAP, then IDLE; no partial result discarded.
// - dist_bus slices hold value until overwritten; timeout bit cleared by next valid measurement of that sensor.
// - Only one trig bit high at any time; trig never high outside TRIG.
// - Latency: echo pin fall -> dist_vld = 2 sync cycles + 1 MEAS detect + 1 RESULT = 4 cycles.
// TESTING (bench params: N_SENS=3, TRIG_CYC=4, WAIT_TO=50, ECHO_MAX=200, GAP_CYC=10, MM_MUL=65536)
// - Reset release, en=1: trig[0] high exactly 4 cycles; dist_bus=48'hFFFF_FFFF_FFFF until first result.
// - Sensor 0 echo high 100 cycles, 20 cycles after trig fall -> dist_vld, dist_id=0, slice0=100, timeout[0]=0, 4 cycles after echo fall.
// - Sensor 1 echo never rises -> after 50 WAIT cycles slice1=16'hFFFF, timeout[1]=1; trig[2] fires 10 cycles later.
// - Sensor 2 echo held high 300 cycles -> timeout at 200 MEAS cycles, slice2=16'hFFFF; next scan returns to sensor 0 (sel wrap).
// - en dropped during sensor 0 MEAS -> result published, GAP runs, then IDLE, busy=0, no further trig.
// - reset asserted during TRIG -> trig, busy, dist_vld immediately 0; all slices back to 16'hFFFF; restart at sensor 0.

Source files
------------

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin scan controller for up to four HC-SR04-style rangers sharing one
// echo timer: trigger, time echo, convert to mm, publish, then hold off for crosstalk.
module ultrasonic_scan_ctrl #(
    parameter int N_SENS   = 3,
    parameter int TRIG_CYC = 500,
    parameter int WAIT_TO  = 1500000,
    parameter int ECHO_MAX = 1250000,
    parameter int GAP_CYC  = 3000000,
    parameter int MM_MUL   = 223
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [N_SENS-1:0]     echo,
    output logic [N_SENS-1:0]     trig,
    output logic [16*N_SENS-1:0]  dist_bus,
    output logic                  dist_vld,
    output logic [1:0]            dist_id,
    output logic [N_SENS-1:0]     timeout,
    output logic                  busy
);

    localparam int MAX_TW  = (TRIG_CYC > WAIT_TO) ? TRIG_CYC : WAIT_TO;
    localparam int MAX_EG  = (ECHO_MAX > GAP_CYC) ? ECHO_MAX : GAP_CYC;
    localparam int CNT_MAX = (MAX_TW > MAX_EG) ? MAX_TW : MAX_EG;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_RESULT,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          armed_q, armed_d;
    logic [20:0]   cycles_q, cycles_d;
    logic          to_q, to_d;

    logic [N_SENS-1:0] echo_m, echo_s;
    logic              echo_cur;
    logic [37:0]       prod;
    logic [21:0]       scaled;
    logic [15:0]       dist_mm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_m <= '0;
            echo_s <= '0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    always_comb begin
        echo_cur = 1'b0;
        trig     = '0;
        for (int i = 0; i < N_SENS; i++) begin
            if (sel_q == 2'(i)) begin
                echo_cur = echo_s[i];
                trig[i]  = (state_q == S_TRIG);
            end
        end
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            armed_q  <= 1'b0;
            cycles_q <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            armed_q  <= armed_d;
            cycles_q <= cycles_d;
            to_q     <= to_d;
        end
    end

    // WAIT only accepts a rising edge: armed is set once echo has been seen low,
    // so an echo still high from a previous ping runs into the timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        armed_d  = armed_q;
        cycles_d = cycles_q;
        to_d     = to_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_TRIG;
                    cnt_d   = '0;
                end
            end
            S_TRIG: begin
                if (cnt_q == CW'(TRIG_CYC - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (armed_q && echo_cur) begin
                    state_d = S_MEAS;
                    cnt_d   = CW'(1);
                end else if (cnt_q == CW'(WAIT_TO - 1)) begin
                    state_d  = S_RESULT;
                    to_d     = 1'b1;
                    cycles_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!echo_cur) armed_d = 1'b1;
                end
            end
            S_MEAS: begin
                if (!echo_cur) begin
                    state_d  = S_RESULT;
                    to_d     = 1'b0;
                    cycles_d = 21'(cnt_q);
                end else if (cnt_q == CW'(ECHO_MAX)) begin
                    state_d  = S_RESULT;
                    to_d     = 1'b1;
                    cycles_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESULT: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    sel_d   = (sel_q == 2'(N_SENS - 1)) ? 2'd0 : sel_q + 2'd1;
                    state_d = en ? S_TRIG : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Full-width product; 16'hFFFF is reserved as the "no valid reading" marker.
    assign prod    = 38'(cycles_q) * 38'(MM_MUL);
    assign scaled  = 22'(prod >> 16);
    assign dist_mm = to_q ? 16'hFFFF :
                     (scaled > 22'h00FFFE) ? 16'hFFFE : scaled[15:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dist_bus <= '1;
            dist_vld <= 1'b0;
            dist_id  <= '0;
            timeout  <= '0;
        end else begin
            dist_vld <= (state_q == S_RESULT);
            if (state_q == S_RESULT) begin
                dist_id <= sel_q;
                for (int i = 0; i < N_SENS; i++) begin
                    if (sel_q == 2'(i)) begin
                        dist_bus[16*i +: 16] <= dist_mm;
                        timeout[i]           <= to_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Directed bench for ultrasonic_scan_ctrl with short timing parameters; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_ultrasonic_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  echo;
    logic [2:0]  trig;
    logic [47:0] dist_bus;
    logic        dist_vld;
    logic [1:0]  dist_id;
    logic [2:0]  timeout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    ultrasonic_scan_ctrl #(
        .N_SENS   (3),
        .TRIG_CYC (4),
        .WAIT_TO  (50),
        .ECHO_MAX (200),
        .GAP_CYC  (10),
        .MM_MUL   (65536)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .echo     (echo),
        .trig     (trig),
        .dist_bus (dist_bus),
        .dist_vld (dist_vld),
        .dist_id  (dist_id),
        .timeout  (timeout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_trig(input logic [2:0] pat, output int n);
        n = 0;
        while (trig !== pat && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic trig_width(input logic [2:0] pat, output int n);
        n = 0;
        while (trig === pat && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        while (dist_vld !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int   n;
        logic quiet;

        reset = 1'b0;
        en    = 1'b0;
        echo  = 3'b000;
        repeat (3) tick();
        chk("rst_trig", trig, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_vld", dist_vld, 1'b0);
        chk("rst_id", dist_id, 2'd0);
        chk("rst_timeout", timeout, 3'b000);
        chk("rst_bus", dist_bus, 48'hFFFF_FFFF_FFFF);

        // sensor 0 normal echo of 100 cycles
        reset = 1'b1;
        en    = 1'b1;
        tick();
        chk("s0_trig_on", trig, 3'b001);
        chk("s0_busy", busy, 1'b1);
        trig_width(3'b001, n);
        chk("s0_trig_width", n, 4);
        chk("s0_bus_pre", dist_bus, 48'hFFFF_FFFF_FFFF);
        repeat (20) tick();
        echo[0] = 1'b1;
        repeat (100) tick();
        echo[0] = 1'b0;
        repeat (3) tick();
        chk("s0_vld_early", dist_vld, 1'b0);
        tick();
        chk("s0_vld", dist_vld, 1'b1);
        chk("s0_id", dist_id, 2'd0);
        chk("s0_dist", dist_bus[15:0], 16'd100);
        chk("s0_timeout", timeout, 3'b000);
        chk("s0_others", dist_bus[47:16], 32'hFFFF_FFFF);
        tick();
        chk("s0_vld_pulse", dist_vld, 1'b0);

        // sensor 1 never echoes
        wait_trig(3'b010, n);
        chk("s1_trig_on", trig, 3'b010);
        chk("s1_gap_len", n, 9);
        trig_width(3'b010, n);
        chk("s1_trig_width", n, 4);
        wait_vld(n);
        chk("s1_wait_to", n, 51);
        chk("s1_id", dist_id, 2'd1);
        chk("s1_dist", dist_bus[31:16], 16'hFFFF);
        chk("s1_timeout", timeout, 3'b010);
        chk("s1_s0_hold", dist_bus[15:0], 16'd100);
        wait_trig(3'b100, n);
        chk("s2_trig_on", trig, 3'b100);
        chk("s2_gap_len", n, 10);

        // sensor 2 echo overlong
        trig_width(3'b100, n);
        repeat (5) tick();
        echo[2] = 1'b1;
        wait_vld(n);
        chk("s2_echo_to", n, 204);
        chk("s2_id", dist_id, 2'd2);
        chk("s2_dist", dist_bus[47:32], 16'hFFFF);
        chk("s2_timeout", timeout, 3'b110);
        echo[2] = 1'b0;

        // wrap to sensor 0, then drop en mid-measurement
        wait_trig(3'b001, n);
        chk("wrap_trig", trig, 3'b001);
        chk("wrap_gap_len", n, 10);
        trig_width(3'b001, n);
        repeat (5) tick();
        echo[0] = 1'b1;
        repeat (10) tick();
        en = 1'b0;
        repeat (20) tick();
        echo[0] = 1'b0;
        repeat (4) tick();
        chk("endrop_vld", dist_vld, 1'b1);
        chk("endrop_id", dist_id, 2'd0);
        chk("endrop_dist", dist_bus[15:0], 16'd30);
        chk("endrop_timeout", timeout, 3'b110);
        repeat (9) tick();
        chk("endrop_gap_busy", busy, 1'b1);
        tick();
        chk("endrop_idle", busy, 1'b0);
        quiet = 1'b1;
        repeat (30) begin
            tick();
            if (trig !== 3'b000 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("endrop_quiet", quiet, 1'b1);

        // resume at sensor 1; valid reading clears its timeout
        en = 1'b1;
        tick();
        chk("resume_trig", trig, 3'b010);
        trig_width(3'b010, n);
        repeat (3) tick();
        echo[1] = 1'b1;
        repeat (7) tick();
        echo[1] = 1'b0;
        repeat (4) tick();
        chk("s1b_vld", dist_vld, 1'b1);
        chk("s1b_dist", dist_bus[31:16], 16'd7);
        chk("s1b_timeout", timeout, 3'b100);

        // sensor 2 echo already high when WAIT starts
        echo[2] = 1'b1;
        wait_trig(3'b100, n);
        chk("stuck_trig", trig, 3'b100);
        trig_width(3'b100, n);
        wait_vld(n);
        chk("stuck_wait_to", n, 51);
        chk("stuck_dist", dist_bus[47:32], 16'hFFFF);
        echo[2] = 1'b0;

        // reset during TRIG
        wait_trig(3'b001, n);
        chk("pre_rst_trig", trig, 3'b001);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("arst_trig", trig, 3'b000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_vld", dist_vld, 1'b0);
        chk("arst_bus", dist_bus, 48'hFFFF_FFFF_FFFF);
        chk("arst_timeout", timeout, 3'b000);
        tick();
        reset = 1'b1;
        tick();
        chk("restart_trig", trig, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
